// File: rtl/mul_pkg.sv
// Shared constants, types and helpers for the Booth/Wallace multiplier.
// No ports; imported by booth_wallace and booth_mul.
package mul_pkg;

  localparam int MUL_OP_W = 3;
  localparam int MUL_W    = 0;
  localparam int MULH_W   = 1;
  localparam int MULH_WU  = 2;
  localparam int OPND_W   = 32;
  localparam int PROD_W   = 64;
  localparam int PP_N     = 17;

  typedef struct packed {
    logic [PROD_W-1:0] sum;
    logic [PROD_W-1:0] carry;
  } cs_t;

  // 3:2 carry-save compressor over full product width
  function automatic cs_t csa(
    input logic [PROD_W-1:0] a,
    input logic [PROD_W-1:0] b,
    input logic [PROD_W-1:0] c
  );
    cs_t r;
    r.sum   = a ^ b ^ c;
    r.carry = ((a & b) | (a & c) | (b & c)) << 1;
    return r;
  endfunction

  // Radix-4 Booth digit applied to the extended multiplicand
  function automatic logic [PROD_W-1:0] booth_pp(
    input logic [2:0]        d,
    input logic [PROD_W-1:0] a
  );
    logic [PROD_W-1:0] r;
    case (d)
      3'b001, 3'b010: r = a;
      3'b011:         r = a << 1;
      3'b100:         r = -(a << 1);
      3'b101, 3'b110: r = -a;
      default:        r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/booth_wallace.sv
// 33x33 radix-4 Booth partial products + Wallace reduction to sum/carry.
// Ports: a, b (33-bit extended operands), cs (sum/carry, mod 2^64).
module booth_wallace
  import mul_pkg::*;
(
  input  logic [OPND_W:0] a,
  input  logic [OPND_W:0] b,
  output cs_t             cs
);

  logic [PROD_W-1:0] a_x;
  logic [OPND_W+2:0] b_x;
  logic [PROD_W-1:0] pp [PP_N];
  logic [PROD_W-1:0] l1 [12];
  logic [PROD_W-1:0] l2 [8];
  logic [PROD_W-1:0] l3 [6];
  logic [PROD_W-1:0] l4 [4];
  logic [PROD_W-1:0] l5 [3];
  cs_t t;

  assign a_x = {{(PROD_W-OPND_W-1){a[OPND_W]}}, a};
  // implicit zero below bit 0, sign copy above bit 32
  assign b_x = {b[OPND_W], b, 1'b0};

  for (genvar i = 0; i < PP_N; i++) begin : g_pp
    assign pp[i] = booth_pp(b_x[2*i +: 3], a_x) << (2*i);
  end

  // 17 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2
  always_comb begin
    t = '0;
    for (int g = 0; g < 5; g++) begin
      t = csa(pp[3*g], pp[3*g+1], pp[3*g+2]);
      l1[2*g]   = t.sum;
      l1[2*g+1] = t.carry;
    end
    l1[10] = pp[15];
    l1[11] = pp[16];
    for (int g = 0; g < 4; g++) begin
      t = csa(l1[3*g], l1[3*g+1], l1[3*g+2]);
      l2[2*g]   = t.sum;
      l2[2*g+1] = t.carry;
    end
    for (int g = 0; g < 2; g++) begin
      t = csa(l2[3*g], l2[3*g+1], l2[3*g+2]);
      l3[2*g]   = t.sum;
      l3[2*g+1] = t.carry;
    end
    l3[4] = l2[6];
    l3[5] = l2[7];
    for (int g = 0; g < 2; g++) begin
      t = csa(l3[3*g], l3[3*g+1], l3[3*g+2]);
      l4[2*g]   = t.sum;
      l4[2*g+1] = t.carry;
    end
    t = csa(l4[0], l4[1], l4[2]);
    l5[0] = t.sum;
    l5[1] = t.carry;
    l5[2] = l4[3];
    cs = csa(l5[0], l5[1], l5[2]);
  end

endmodule

// File: rtl/booth_mul.sv
// Pipelined 32x32 multiplier with valid/ready on both sides; 64-bit product.
// Ports: clk, resetn, in_valid/in_ready/in_mul_op/in_src1/in_src2, out_valid/out_ready/out_result.
// BOOTH_MUL_STAGE3_EN adds a register before the final adder (latency 3).
module booth_mul
  import mul_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_mul_op,
  input  logic [OPND_W-1:0]   in_src1,
  input  logic [OPND_W-1:0]   in_src2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   out_result
);

  logic            sgn;
  logic            op_unused;
  logic [OPND_W:0] a_x;
  logic [OPND_W:0] b_x;
  cs_t             tree_cs;

  logic s1_valid;
  cs_t  s1_cs;
  logic s1_ld;
  logic out_ld;
  logic fin_valid;
  cs_t  fin_cs;

  // mulh.wu and empty/odd codes all fall through to unsigned
  assign sgn       = in_mul_op[MUL_W] | in_mul_op[MULH_W];
  assign op_unused = in_mul_op[MULH_WU];
  assign a_x       = {sgn & in_src1[OPND_W-1], in_src1};
  assign b_x       = {sgn & in_src2[OPND_W-1], in_src2};

  booth_wallace u_tree (
    .a  (a_x),
    .b  (b_x),
    .cs (tree_cs)
  );

  assign out_ld   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_ld;

`ifdef BOOTH_MUL_STAGE3_EN
  logic s2_valid;
  cs_t  s2_cs;
  logic s2_ld;

  assign s2_ld     = !s2_valid || out_ld;
  assign s1_ld     = s2_ld;
  assign fin_valid = s2_valid;
  assign fin_cs    = s2_cs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      s2_valid <= 1'b0;
    else if (s2_ld)
      s2_valid <= s1_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_valid && s2_ld)
      s2_cs <= s1_cs;
  end
`else
  assign s1_ld     = out_ld;
  assign fin_valid = s1_valid;
  assign fin_cs    = s1_cs;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      s1_valid <= 1'b0;
    else if (in_ready)
      s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready)
      s1_cs <= tree_cs;
  end

  // result only moves together with a valid product
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (out_ld) begin
      out_valid <= fin_valid;
      if (fin_valid)
        out_result <= fin_cs.sum + fin_cs.carry;
    end
  end

endmodule

// File: tb/tb_booth_mul.sv
// Self-checking bench for booth_mul: queue model + directed vectors.
// Honours BOOTH_MUL_STAGE3_EN for the expected latency.
module tb_booth_mul;
  import mul_pkg::*;

`ifdef BOOTH_MUL_STAGE3_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mul_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;

  booth_mul dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mul_op  (in_mul_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int del_cnt = 0;
  logic [63:0] exp_q [$];

  function automatic logic [63:0] model(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b
  );
    logic [63:0] x, y;
    if (op[0] | op[1]) begin
      x = {{32{a[31]}}, a};
      y = {{32{b[31]}}, b};
    end else begin
      x = {32'h0, a};
      y = {32'h0, b};
    end
    return x * y;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) exp_q.delete();
    else if (in_valid && in_ready) begin
      exp_q.push_back(model(in_mul_op, in_src1, in_src2));
      acc_cnt++;
    end
  end

  logic [63:0] prev_res;
  logic have_prev = 1'b0;
  logic prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!resetn) begin
      have_prev = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (have_prev && (prev_stall || !out_valid))
        chk("hold_result", out_result, prev_res);
      if (have_prev && prev_stall)
        chk("hold_valid", {63'h0, out_valid}, 64'h1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious: got %h want none", out_result);
        end else begin
          del_cnt++;
          chk("result", out_result, exp_q.pop_front());
        end
      end
      prev_res = out_result;
      prev_stall = out_valid && !out_ready;
      have_prev = 1'b1;
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_mul_op = op;
    in_src1 = a;
    in_src2 = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 want 1");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain", 64'(exp_q.size()), 64'h0);
  endtask

  logic [2:0]  vop [8];
  logic [31:0] va  [8];
  logic [31:0] vb  [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int n, a0, d0;
    vop[0] = 3'b100; va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF;
    vop[1] = 3'b010; va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF;
    vop[2] = 3'b001; va[2] = 32'hFFFFFFFF; vb[2] = 32'hFFFFFFFF;
    vop[3] = 3'b010; va[3] = 32'h80000000; vb[3] = 32'h80000000;
    vop[4] = 3'b100; va[4] = 32'h80000000; vb[4] = 32'h80000000;
    vop[5] = 3'b000; va[5] = 32'hFFFFFFFF; vb[5] = 32'h00000002;
    vop[6] = 3'b110; va[6] = 32'hFFFFFFFF; vb[6] = 32'h00000002;
    vop[7] = 3'b011; va[7] = 32'h12345678; vb[7] = 32'hFEDCBA98;

    resetn = 1'b0;
    in_valid = 1'b0;
    in_mul_op = 3'b000;
    in_src1 = '0;
    in_src2 = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_result", out_result, 64'h0);

    chk("pin_smax", model(3'b010, 32'h7FFFFFFF, 32'h7FFFFFFF), 64'h3FFFFFFF00000001);
    chk("pin_uneg", model(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE00000001);
    chk("pin_sneg", model(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'h0000000000000001);
    chk("pin_mulw", {32'h0, model(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF)}, 64'h1);
    chk("pin_smin", model(3'b010, 32'h80000000, 32'h80000000), 64'h4000000000000000);
    chk("pin_umin", model(3'b100, 32'h80000000, 32'h80000000), 64'h4000000000000000);
    chk("pin_op0", model(3'b000, 32'hFFFFFFFF, 32'h2), 64'h00000001FFFFFFFE);
    chk("pin_multi", model(3'b110, 32'hFFFFFFFF, 32'h2), 64'hFFFFFFFFFFFFFFFE);

    // signed max and latency counted in edges from the accept edge
    send(3'b010, 32'h7FFFFFFF, 32'h7FFFFFFF);
    idle();
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(LAT));
    chk("smax_lit", out_result, 64'h3FFFFFFF00000001);
    drain();

    for (int i = 0; i < 8; i++) send(vop[i], va[i], vb[i]);
    idle();
    drain();

    // back-pressure: out_ready low for 5 cycles over 4 requests
    out_ready = 1'b0;
    a0 = acc_cnt;
    d0 = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(vop[i+3], va[i+3], vb[i+3]);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp_held", 64'(acc_cnt - a0), 64'(LAT));
        chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        d0 = del_cnt;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_burst", 64'(del_cnt - d0), 64'h4);
      end
    join
    drain();

    // reset one cycle after an accept
    send(3'b010, 32'h3, 32'h5);
    idle();
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    chk("mid_out_valid", {63'h0, out_valid}, 64'h0);
    chk("mid_result", out_result, 64'h0);
    chk("mid_in_ready", {63'h0, in_ready}, 64'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("mid_quiet", {63'h0, out_valid}, 64'h0);
    end
    d0 = del_cnt;
    send(3'b100, 32'h12345678, 32'h9ABCDEF0);
    idle();
    drain();
    chk("mid_after", 64'(del_cnt - d0), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
